cheat_code_loader: RTL and testbench

- Sequences a downloaded cheat file into the cheat-code match engine.
- Accepts a 16-bit word stream in file order and assembles 128-bit codes: four 32-bit fields (flags, address, compare, replace), each stored little-endian in the file.
- Presents each code big-endian on the engine's 129-bit code bus and produces the rising-edge load strobe the engine expects.
- Clears the engine before every new code set and enforces the engine's code capacity.

---
 rtl/cheat_code_loader.sv | 118 +++++++++++
 tb/tb_cheat_code_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cheat_code_loader.sv
// cheat_code_loader: turns a 16-bit cheat-file word stream into strobed 129-bit engine codes
// Ports: clk, reset (sync, active-high); load_begin/load_end set framing pulses;
//   in_valid/in_ready/in_data word handshake; engine_clear engine reset;
//   code_out {strobe, flags, addr, compare, replace}; codes_loaded count; busy; overflow (sticky).
// Optional: define CHEAT_ZERO_SKIP_EN to drop all-zero codes as file padding.
module cheat_code_loader #(
    parameter int MAX_CODES    = 32,
    parameter int STROBE_HOLD  = 2,
    parameter int CLEAR_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load_begin,
    input  logic                           load_end,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [15:0]                    in_data,
    output logic                           engine_clear,
    output logic [128:0]                   code_out,
    output logic [$clog2(MAX_CODES+1)-1:0] codes_loaded,
    output logic                           busy,
    output logic                           overflow
);
    localparam int CW = $clog2(MAX_CODES + 1);
    localparam int HOLD_MAX = CLEAR_CYCLES > STROBE_HOLD ? CLEAR_CYCLES : STROBE_HOLD;
    localparam int TW = $clog2(HOLD_MAX + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, RECV, STROBE_HI, STROBE_LO} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer;
    logic [2:0]    word_cnt;
    logic          full, pending_end, take, last_clear, last_hold, accept, skip;
    logic [15:0]   words [8];
    logic [127:0]  assembled, code_q;

    assign take       = in_valid && in_ready;
    assign last_clear = timer == TW'(CLEAR_CYCLES - 1);
    assign last_hold  = timer == TW'(STROBE_HOLD - 1);
`ifdef CHEAT_ZERO_SKIP_EN
    assign skip = assembled == '0;
`else
    assign skip = 1'b0;
`endif
    // full marks the cycle after the 8th word, when the code is judged and latched
    assign accept = full && !skip && codes_loaded < CW'(MAX_CODES);

    // each 32-bit field is two little-endian words; field 0 lands in the top bits
    always_comb begin
        assembled = '0;
        for (int i = 0; i < 4; i++)
            assembled[127-32*i -: 32] = {words[2*i+1], words[2*i]};
    end

    always_ff @(posedge clk)
        if (take) words[word_cnt] <= in_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            word_cnt     <= '0;
            full         <= 1'b0;
            pending_end  <= 1'b0;
            codes_loaded <= '0;
            overflow     <= 1'b0;
            code_q       <= '0;
        end else begin
            state <= state_nxt;
            timer <= (state_nxt != state || load_begin) ? '0 : timer + 1'b1;
            if (load_begin) begin
                word_cnt     <= '0;
                full         <= 1'b0;
                pending_end  <= 1'b0;
                codes_loaded <= '0;
                overflow     <= 1'b0;
            end else begin
                if (take) begin
                    word_cnt <= word_cnt + 1'b1;
                    full     <= word_cnt == 3'd7;
                end
                if (full) begin
                    full <= 1'b0;
                    if (!skip) code_q <= assembled;
                    if (accept) codes_loaded <= codes_loaded + 1'b1;
                    else if (!skip) overflow <= 1'b1;
                end
                if (load_end && state == RECV && !full) begin
                    word_cnt <= '0;
                    full     <= 1'b0;
                end
                if (load_end && state != IDLE) pending_end <= 1'b1;
                if (state_nxt == IDLE) pending_end <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (load_begin) state_nxt = CLEAR;
        else case (state)
            IDLE:      state_nxt = IDLE;
            CLEAR:     state_nxt = !last_clear ? CLEAR : (pending_end || load_end) ? IDLE : RECV;
            // a complete code is still strobed even if load_end arrives with it
            RECV:      state_nxt = accept ? STROBE_HI : load_end ? IDLE : RECV;
            STROBE_HI: state_nxt = last_hold ? STROBE_LO : STROBE_HI;
            STROBE_LO: state_nxt = !last_hold ? STROBE_LO : (pending_end || load_end) ? IDLE : RECV;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready     = state == RECV && !full;
        engine_clear = state == CLEAR;
        busy         = state != IDLE;
        code_out     = {state == STROBE_HI, code_q};
    end
endmodule

// File: tb/tb_cheat_code_loader.sv
// tb_cheat_code_loader: randomized directed bench with a byte-level reference model
module tb_cheat_code_loader;
    localparam int MAXC = 32;
    localparam logic [127:0] PLAN_FILE = 128'h000000BB_000000AA_00001234_00000001;
    localparam logic [127:0] PLAN_CODE = 128'h00000001_00001234_000000AA_000000BB;
`ifdef CHEAT_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, load_begin, load_end, in_valid, in_ready, engine_clear, busy, overflow;
    logic [15:0] in_data;
    logic [128:0] code_out;
    logic [5:0] codes_loaded;

    int n_checks = 0, n_errors = 0;
    logic [127:0] strobes[$], exp_q[$];
    logic prev_strobe = 1'b0;
    int m_count = 0;
    logic m_ovf = 1'b0;
    logic [127:0] m_last = '0;

    always #5 clk = ~clk;

    cheat_code_loader dut (
        .clk(clk), .reset(reset), .load_begin(load_begin), .load_end(load_end),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .engine_clear(engine_clear), .code_out(code_out), .codes_loaded(codes_loaded),
        .busy(busy), .overflow(overflow)
    );

    always @(negedge clk) begin
        if (code_out[128] && !prev_strobe) strobes.push_back(code_out[127:0]);
        prev_strobe = code_out[128];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [128:0] got, input logic [128:0] want);
        n_checks++;
        assert (got === want) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic timeout(input string tag);
        n_checks++;
        n_errors++;
        $error("FAIL %s: got timeout expected DUT response", tag);
    endtask

    // the file stores bytes in order; each 32-bit field is little-endian, fields go out big-endian
    function automatic logic [127:0] exp_of(input logic [127:0] file);
        return {file[31:0], file[63:32], file[95:64], file[127:96]};
    endfunction

    function automatic logic [127:0] rand_file();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic begin_set();
        load_begin = 1'b1;
        tick();
        load_begin = 1'b0;
        strobes.delete();
        exp_q.delete();
        m_count = 0;
        m_ovf = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int t = 0;
        while (!in_ready && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) timeout(tag);
    endtask

    task automatic send_word(input logic [15:0] w, input int gap);
        in_valid = 1'b1;
        in_data = w;
        wait_ready("ready_wait");
        tick();
        in_valid = 1'b0;
        in_data = 16'($urandom);
        repeat (gap) tick();
    endtask

    // mode 0 back-to-back, 1 alternate idle cycles, 2 random gaps; never a gap after the last word
    task automatic send_code(input logic [127:0] file, input int mode);
        logic [127:0] c;
        for (int k = 0; k < 8; k++)
            send_word(file[16*k +: 16], k == 7 ? 0 : mode == 0 ? 0 : mode == 1 ? 1 : int'($urandom_range(0, 2)));
        c = exp_of(file);
        if (!(SKIP && c == '0)) begin
            m_last = c;
            if (m_count < MAXC) begin
                exp_q.push_back(c);
                m_count++;
            end else m_ovf = 1'b1;
        end
    endtask

    task automatic check_set(input string tag);
        int t = 0;
        while (!(in_ready || !busy) && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) timeout({tag, "_settle"});
        chk({tag, "_count"}, codes_loaded, m_count);
        chk({tag, "_overflow"}, overflow, m_ovf);
        chk({tag, "_strobes"}, strobes.size(), exp_q.size());
        for (int i = 0; i < strobes.size() && i < exp_q.size(); i++)
            chk({tag, "_code"}, strobes[i], exp_q[i]);
        chk({tag, "_last"}, code_out[127:0], m_last);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        load_begin = 1'b0;
        load_end = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) tick();
        chk("rst_code", code_out, '0);
        chk("rst_count", codes_loaded, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_clear", engine_clear, 0);
        reset = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        begin_set();
        n = 0;
        for (int i = 0; i < 20 && engine_clear; i++) begin
            n++;
            tick();
        end
        chk("clear_len", n, 4);
        chk("clear_ready", in_ready, 1);
        send_code(PLAN_FILE, 0);
        chk("lat_t1", code_out[128], 0);
        tick();
        chk("lat_t2", code_out[128], 1);
        chk("plan_code", code_out[127:0], PLAN_CODE);
        chk("plan_count", codes_loaded, 1);
        tick();
        chk("hi_2", code_out[128], 1);
        tick();
        chk("lo_1", code_out[128], 0);
        tick();
        chk("lo_2", code_out[128], 0);
        chk("lo_busy", busy, 1);
        tick();
        chk("recv_ready", in_ready, 1);
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        chk("end_idle", busy, 0);
        check_set("plan");

        begin_set();
        repeat (33) send_code(rand_file(), 2);
        check_set("ovf");

        for (int k = 0; k < 3; k++) send_word(16'($urandom), 0);
        begin_set();
        wait_ready("rb_ready");
        chk("rb_ovf_clear", overflow, 0);
        chk("rb_count_clear", codes_loaded, 0);
        repeat (3) send_code(rand_file(), 1);
        for (int k = 0; k < 3; k++) send_word(16'($urandom), 0);
        chk("rb3_count", codes_loaded, 3);
        begin_set();
        wait_ready("rb3_ready");
        chk("rb3_count_clear", codes_loaded, 0);
        send_code(PLAN_FILE, 0);
        check_set("restart");

        for (int k = 0; k < 5; k++) send_word(16'($urandom), 0);
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        chk("partial_idle", busy, 0);
        repeat (3) tick();
        check_set("partial");
        begin_set();
        send_code(rand_file(), 1);
        check_set("after_partial");

        send_code(rand_file(), 0);
        tick();
        chk("es_hi1", code_out[128], 1);
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        chk("es_hi2", code_out[128], 1);
        tick();
        chk("es_lo1", code_out[128], 0);
        chk("es_busy1", busy, 1);
        tick();
        chk("es_lo2", code_out[128], 0);
        chk("es_busy2", busy, 1);
        tick();
        chk("es_idle", busy, 0);
        chk("es_ready", in_ready, 0);
        check_set("end_strobe");

        begin_set();
        send_code(PLAN_FILE, 1);
        check_set("toggle");
        chk("toggle_code", code_out[127:0], PLAN_CODE);

        begin_set();
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        chk("ec_clear", engine_clear, 1);
        repeat (3) tick();
        chk("ec_idle", busy, 0);
        chk("ec_clear_off", engine_clear, 0);

        begin_set();
        send_code(rand_file(), 2);
        send_code('0, 2);
        send_code(rand_file(), 2);
        check_set("zero");

        begin_set();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_busy", busy, 0);
        chk("mr_clear", engine_clear, 0);
        chk("mr_code", code_out, '0);
        chk("mr_count", codes_loaded, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
